membrane_integrator: RTL

Upstream neighbour of the activation unit in the spiking datapath. Holds one signed membrane potential per neuron lane and, over a fixed inference window of TIMESTEPS steps, integrates the incoming synaptic current with leak. Presents the potentials to the activation unit. On the spike feedback it returns, subtracts the threshold from every lane that fired (reset-by-subtraction).

---
 rtl/membrane_integrator.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/membrane_integrator.sv
// Per-lane leaky membrane integrator for the spiking datapath: integrates synaptic
// current with arithmetic-shift leak over a window of TIMESTEPS steps, with reset-by-subtraction on spikes.
module membrane_integrator #(
    parameter int NUM_NEURONS = 2,
    parameter int DATA_WIDTH  = 16,
    parameter int LEAK_SHIFT  = 4,
    parameter int TIMESTEPS   = 16,
    parameter int TS_WIDTH    = 5
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] in_current,
    input  logic [NUM_NEURONS*DATA_WIDTH-1:0] threshold,
    input  logic                              spike_valid,
    input  logic [NUM_NEURONS-1:0]            spike_in,
    output logic [NUM_NEURONS*DATA_WIDTH-1:0] membrane_potential,
    output logic                              mp_valid,
    output logic [TS_WIDTH-1:0]               timestep,
    output logic                              busy,
    output logic                              done
);

    localparam int W  = DATA_WIDTH;
    localparam int EW = DATA_WIDTH + 2;
    localparam logic signed [EW-1:0]  SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [EW-1:0]  SAT_MIN = {3'b111, {(W-1){1'b0}}};
    localparam logic [TS_WIDTH-1:0]   LAST_TS = TS_WIDTH'(TIMESTEPS - 1);

    typedef enum logic [1:0] {
        IDLE,
        INTEGRATE,
        WAIT_SPIKE,
        DONE
    } state_t;

    state_t state, state_next;

    logic [NUM_NEURONS*W-1:0] integ_next;
    logic [NUM_NEURONS*W-1:0] spike_next;

    // Two guard bits keep v - leak + current exact before clamping back to W bits.
    function automatic logic [W-1:0] saturate(input logic signed [EW-1:0] x);
        if (x > SAT_MAX)
            return SAT_MAX[W-1:0];
        else if (x < SAT_MIN)
            return SAT_MIN[W-1:0];
        else
            return x[W-1:0];
    endfunction

    function automatic logic [W-1:0] integrate(input logic [W-1:0] v, input logic [W-1:0] c);
        logic signed [EW-1:0] v_ext;
        logic signed [EW-1:0] c_ext;
        v_ext = EW'($signed(v));
        c_ext = EW'($signed(c));
        return saturate(v_ext - (v_ext >>> LEAK_SHIFT) + c_ext);
    endfunction

    function automatic logic [W-1:0] subtract(input logic [W-1:0] v, input logic [W-1:0] th);
        logic signed [EW-1:0] v_ext;
        logic signed [EW-1:0] th_ext;
        v_ext  = EW'($signed(v));
        th_ext = EW'($signed(th));
        return saturate(v_ext - th_ext);
    endfunction

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        integ_next = '0;
        spike_next = '0;
        for (int i = 0; i < NUM_NEURONS; i++) begin
            integ_next[i*W +: W] = integrate(membrane_potential[i*W +: W], in_current[i*W +: W]);
            spike_next[i*W +: W] = spike_in[i] ? subtract(membrane_potential[i*W +: W], threshold[i*W +: W])
                                               : membrane_potential[i*W +: W];
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start)
                    state_next = INTEGRATE;
            end
            INTEGRATE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_next = WAIT_SPIKE;
            end
            WAIT_SPIKE: begin
                if (spike_valid)
                    state_next = (timestep == LAST_TS) ? DONE : INTEGRATE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            membrane_potential <= '0;
            timestep           <= '0;
            mp_valid           <= 1'b0;
        end else begin
            mp_valid <= (state == INTEGRATE) && in_valid;
            case (state)
                IDLE: begin
                    if (start) begin
                        membrane_potential <= '0;
                        timestep           <= '0;
                    end
                end
                INTEGRATE: begin
                    if (in_valid)
                        membrane_potential <= integ_next;
                end
                WAIT_SPIKE: begin
                    if (spike_valid) begin
                        membrane_potential <= spike_next;
                        timestep <= (timestep == LAST_TS) ? '0 : timestep + TS_WIDTH'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
